// File: rtl/ysyx_25060170_fetch_req.sv
// Fetch-request stage: owns the PC, issues one AXI4-Lite-style instruction read at a
// time and holds the returned word with its PC until the IF stage takes it.
module ysyx_25060170_fetch_req #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        core_ready,

    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    output logic        inst_valid,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // arvalid/rready/inst_valid are pure decodes of the registered state, so once raised
    // they and their payload hold until the transfer (or, for inst_valid, a redirect).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] req_addr;
    logic [31:0] req_addr_nxt;
    logic [31:0] inst_q;
    logic [31:0] inst_nxt;
    logic        err_q;
    logic        err_nxt;
    logic        discard;
    logic        discard_nxt;

    logic [31:0] redirect_tgt;
    logic [31:0] seq_addr;
    logic        drop_resp;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign seq_addr     = req_addr + 32'd4;
    // A response is stale if a redirect arrived earlier or arrives together with it.
    assign drop_resp    = discard | redirect_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (arready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (rvalid) begin
                    state_nxt = drop_resp ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || core_ready) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        arvalid    = (state == REQ);
        rready     = (state == WAIT);
        inst_valid = (state == HOLD);
        araddr     = req_addr;
        pc_o       = req_addr;
        inst_o     = inst_q;
        inst_err   = err_q;
    end

    // Datapath next values
    always_comb begin
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        inst_nxt     = inst_q;
        err_nxt      = err_q;
        discard_nxt  = discard;

        if (redirect_valid) begin
            pc_nxt = redirect_tgt;
        end

        case (state)
            IDLE: begin
                req_addr_nxt = redirect_valid ? redirect_tgt : pc;
            end
            REQ: begin
                // araddr must not move while arvalid is up, so only remember the squash.
                if (redirect_valid) begin
                    discard_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (rvalid) begin
                    if (drop_resp) begin
                        discard_nxt  = 1'b0;
                        req_addr_nxt = redirect_valid ? redirect_tgt : pc;
                    end else begin
                        inst_nxt = rdata;
                        err_nxt  = |rresp;
                    end
                end else if (redirect_valid) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    req_addr_nxt = redirect_tgt;
                end else if (core_ready) begin
                    pc_nxt       = seq_addr;
                    req_addr_nxt = seq_addr;
                end
            end
            default: begin
                discard_nxt = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            inst_q   <= 32'd0;
            err_q    <= 1'b0;
            discard  <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            inst_q   <= inst_nxt;
            err_q    <= err_nxt;
            discard  <= discard_nxt;
        end
    end

    // Protocol properties of this block's outputs
    a_araddr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (arvalid && !arready) |=> (arvalid && $stable(araddr)));

    a_single_phase: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({arvalid, rready, inst_valid}));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (inst_valid && !redirect_valid && !core_ready) |=>
        (inst_valid && $stable(inst_o) && $stable(pc_o) && $stable(inst_err)));

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        arvalid |-> (araddr[1:0] == 2'b00));

endmodule

// File: tb/tb_ysyx_25060170_fetch_req.sv
// Bench for ysyx_25060170_fetch_req: directed scenarios plus random memory timing,
// redirects and stalls, checked against a transaction-level fetch model.
module tb_ysyx_25060170_fetch_req;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        core_ready = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        inst_valid;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_err;

    ysyx_25060170_fetch_req #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .core_ready     (core_ready),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .inst_valid     (inst_valid),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .inst_err       (inst_err)
    );

    // Clock
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: which bus phase the fetch is in, the program-order next PC,
    // and the expected delivered instruction {err, pc, inst}.
    bit          m_start, m_ar, m_r, m_hold, m_squash;
    logic [31:0] m_next, m_addr;
    logic [64:0] exp_q[$];

    // Memory responder knobs and state
    int          mem_ar_pct, mem_dly_min, mem_dly_max, mem_err_pct, spur_pct;
    bit          mem_fix_en;
    logic [31:0] mem_fix_data;
    logic [1:0]  mem_fix_resp;
    bit          mem_busy;
    int          mem_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_start  = 1'b1;
        m_ar     = 1'b0;
        m_r      = 1'b0;
        m_hold   = 1'b0;
        m_squash = 1'b0;
        m_next   = RESET_PC;
        m_addr   = RESET_PC;
        exp_q.delete();
        mem_busy = 1'b0;
        mem_cnt  = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_arvalid"},    {31'd0, arvalid},    32'd0);
        check({tag, "_rready"},     {31'd0, rready},     32'd0);
        check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_inst_o"},     inst_o,              32'd0);
        check({tag, "_pc_o"},       pc_o,                RESET_PC);
        check({tag, "_araddr"},     araddr,              RESET_PC);
        check({tag, "_inst_err"},   {31'd0, inst_err},   32'd0);
    endtask

    // One clock cycle, entered at a falling edge: check outputs, drive inputs,
    // advance the model across the coming rising edge, move to the next falling edge.
    task automatic tick(input logic red, input logic [31:0] tgt, input logic cr);
        logic        arr;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [31:0] al;
        logic [64:0] head;

        check("arvalid",    {31'd0, arvalid},    {31'd0, m_ar});
        check("rready",     {31'd0, rready},     {31'd0, m_r});
        check("inst_valid", {31'd0, inst_valid}, {31'd0, m_hold});
        if (m_ar) check("araddr", araddr, m_addr);
        if (m_ar) check("pc_o_req", pc_o, m_addr);
        if (m_hold) begin
            if (exp_q.size() == 0) begin
                check("exp_q_nonempty", 32'd0, 32'd1);
            end else begin
                head = exp_q[0];
                check("inst_o",   inst_o,            head[31:0]);
                check("pc_o",     pc_o,              head[63:32]);
                check("inst_err", {31'd0, inst_err}, {31'd0, head[64]});
            end
        end

        arr = (int'($urandom_range(0, 99)) < mem_ar_pct);
        rv  = 1'b0;
        rd  = $urandom;
        rr  = 2'($urandom_range(0, 3));
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                rv = 1'b1;
                if (mem_fix_en) begin
                    rd = mem_fix_data;
                    rr = mem_fix_resp;
                end else begin
                    rr = (int'($urandom_range(0, 99)) < mem_err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
                end
            end
        end else if (int'($urandom_range(0, 99)) < spur_pct) begin
            rv = 1'b1;
        end

        redirect_valid = red;
        redirect_pc    = tgt;
        core_ready     = cr;
        arready        = arr;
        rvalid         = rv;
        rdata          = rd;
        rresp          = rr;

        al = tgt & 32'hFFFF_FFFC;
        if (m_start) begin
            m_start = 1'b0;
            if (red) m_next = al;
            m_addr = m_next;
            m_ar   = 1'b1;
        end else if (m_ar) begin
            if (red) begin
                m_squash = 1'b1;
                m_next   = al;
            end
            if (arr) begin
                m_ar = 1'b0;
                m_r  = 1'b1;
            end
        end else if (m_r) begin
            if (rv) begin
                if (red) m_next = al;
                m_r = 1'b0;
                if (m_squash || red) begin
                    m_squash = 1'b0;
                    m_ar     = 1'b1;
                    m_addr   = m_next;
                end else begin
                    m_hold = 1'b1;
                    exp_q.push_back({(rr != 2'b00), m_addr, rd});
                end
            end else if (red) begin
                m_squash = 1'b1;
                m_next   = al;
            end
        end else if (m_hold) begin
            if (red || cr) begin
                m_next = red ? al : m_addr + 32'd4;
                void'(exp_q.pop_front());
                m_hold = 1'b0;
                m_ar   = 1'b1;
                m_addr = m_next;
            end
        end

        if (mem_busy) begin
            if (rv && rready) mem_busy = 1'b0;
            else if (mem_cnt > 0) mem_cnt--;
        end else if (arvalid && arr) begin
            mem_busy = 1'b1;
            mem_cnt  = int'($urandom_range(mem_dly_min, mem_dly_max));
        end

        @(negedge clk);
    endtask

    // Idle the core (no redirect, no accept) until the model reaches a phase.
    // what: 0 = address phase, 1 = data phase, 2 = holding an instruction.
    task automatic run_until(input int what, input string tag);
        int  n;
        bit  hit;
        n = 0;
        hit = (what == 0) ? m_ar : (what == 1) ? m_r : m_hold;
        while (!hit && n < 200) begin
            tick(1'b0, 32'd0, 1'b0);
            n++;
            hit = (what == 0) ? m_ar : (what == 1) ? m_r : m_hold;
        end
        check({tag, "_reached"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic set_mem(input int ar_pct, input int dmin, input int dmax,
                           input int err_pct, input int spur);
        mem_ar_pct  = ar_pct;
        mem_dly_min = dmin;
        mem_dly_max = dmax;
        mem_err_pct = err_pct;
        spur_pct    = spur;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] tgt;
        logic        red;

        set_mem(100, 0, 0, 0, 0);
        mem_fix_en   = 1'b1;
        mem_fix_data = 32'h0000_0013;
        mem_fix_resp = 2'b00;
        model_reset();

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        model_reset();

        // Streaming fetch with an always-ready memory and consumer
        repeat (12) tick(1'b0, 32'd0, 1'b1);

        // Consumer stall for five cycles while holding
        run_until(2, "stall");
        repeat (5) tick(1'b0, 32'd0, 1'b0);
        tick(1'b0, 32'd0, 1'b1);
        tick(1'b0, 32'd0, 1'b0);

        // Redirect while waiting for data, before rvalid
        set_mem(100, 2, 2, 0, 0);
        run_until(1, "wait_redir");
        tick(1'b1, 32'h8000_0102, 1'b0);
        run_until(0, "wait_redir_req");
        check("wait_redir_araddr", araddr, 32'h8000_0100);
        run_until(2, "wait_redir_hold");
        check("wait_redir_pc", pc_o, 32'h8000_0100);

        // Redirect during an address phase stalled by arready=0
        set_mem(100, 0, 1, 0, 0);
        tick(1'b0, 32'd0, 1'b1);
        mem_ar_pct = 0;
        tick(1'b1, 32'h8000_0300, 1'b0);
        tick(1'b0, 32'd0, 1'b0);
        tick(1'b0, 32'd0, 1'b0);
        check("req_redir_araddr_old", araddr, 32'h8000_0104);
        mem_ar_pct = 100;
        run_until(2, "req_redir_hold");
        check("req_redir_pc", pc_o, 32'h8000_0300);

        // Redirect wins over core_ready in HOLD
        tick(1'b1, 32'h8000_0010, 1'b0);
        run_until(2, "prio_hold");
        check("prio_pc", pc_o, 32'h8000_0010);
        tick(1'b1, 32'h8000_0200, 1'b1);
        check("prio_araddr", araddr, 32'h8000_0200);

        // PC wrap at the top of the address space
        run_until(2, "wrap_hold0");
        tick(1'b1, 32'hFFFF_FFFF, 1'b0);
        run_until(2, "wrap_hold");
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        tick(1'b0, 32'd0, 1'b1);
        check("wrap_araddr", araddr, 32'h0000_0000);

        // Bus error passes through with the data
        mem_fix_data = 32'hDEAD_BEEF;
        mem_fix_resp = 2'b10;
        run_until(2, "err_hold");
        check("err_flag", {31'd0, inst_err}, 32'd1);
        check("err_inst", inst_o, 32'hDEAD_BEEF);
        tick(1'b0, 32'd0, 1'b1);

        // Asynchronous reset in the middle of a data phase
        set_mem(100, 3, 3, 0, 0);
        run_until(1, "arst_wait");
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(1'b0, 32'd0, 1'b0);
        check("arst_first_araddr", araddr, RESET_PC);

        // Random traffic
        mem_fix_en = 1'b0;
        set_mem(70, 0, 3, 20, 10);
        for (int i = 0; i < 3000; i++) begin
            red = (int'($urandom_range(0, 99)) < 8);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                2:       tgt = RESET_PC + 32'($urandom_range(0, 255));
                default: tgt = 32'($urandom_range(0, 63));
            endcase
            tick(red, tgt, (int'($urandom_range(0, 99)) < 60));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
